// File: rtl/seg7_capture_if.sv
// ---------------------------------------------------------------------------
// seg7_capture_if
// Bundles the 7-segment display bus with the decoded readout it produces.
//   an_i       anode selects, active-low, one low at a time
//   seg_i      shared segments {g,f,e,d,c,b,a}, active-low
//   digits_o   captured 4-bit code per digit, digit k at [4k+3:4k]
//   err_o      per-digit flag: last capture was an unrecognised glyph
//   upd_o      one-cycle pulse when a digit register is written
//   upd_idx_o  index of the digit written, valid with upd_o
//   frame_o    one-cycle pulse when every digit has been captured
// master: the side that drives the display bus and reads the result.
// slave:  the capture block.
// ---------------------------------------------------------------------------
interface seg7_capture_if #(
    parameter int N_DIG = 8
);
    logic [N_DIG-1:0]   an_i;
    logic [6:0]         seg_i;
    logic [4*N_DIG-1:0] digits_o;
    logic [N_DIG-1:0]   err_o;
    logic               upd_o;
    logic [2:0]         upd_idx_o;
    logic               frame_o;

    modport master (
        output an_i, seg_i,
        input  digits_o, err_o, upd_o, upd_idx_o, frame_o
    );

    modport slave (
        input  an_i, seg_i,
        output digits_o, err_o, upd_o, upd_idx_o, frame_o
    );
endinterface

// File: rtl/seg7_capture.sv
// ---------------------------------------------------------------------------
// seg7_capture
// Reader end of a multiplexed, active-low 7-segment display bus. Recovers the
// 4-bit code shown on each digit once its (anode, segment) pair has been
// stable long enough to rule out scan-transition glitches.
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   seg7_capture_if.slave: display bus in, decoded readout out
// Parameters:
//   N_DIG       number of multiplexed digits (1..8)
//   STABLE_CYC  consecutive equal samples required before capture (2..255)
// ---------------------------------------------------------------------------
module seg7_capture #(
    parameter int N_DIG      = 8,
    parameter int STABLE_CYC = 16
) (
    input logic           clk,
    input logic           rst,
    seg7_capture_if.slave bus
);
    localparam logic [7:0] CNT_SAT = 8'(STABLE_CYC);
    // The counter holds the number of equal back-to-back compares already
    // seen; the compare that makes it reach STABLE_CYC-1 is the capture
    // point, which gives an input-to-pulse latency of STABLE_CYC+2 edges.
    localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 2);

    // Two-flop synchronizer plus the previous stage-2 pair.
    logic [N_DIG-1:0] an_m, an_s, an_p;
    logic [6:0]       seg_m, seg_s, seg_p;

    logic [7:0]         cnt;
    logic               armed;
    logic [N_DIG-1:0]   seen;
    logic [4*N_DIG-1:0] digits_q;
    logic [N_DIG-1:0]   err_q;
    logic               upd_q;
    logic [2:0]         idx_q;
    logic               frame_q;

    // Combinational view of the current stage-2 pair.
    logic [3:0]       n_low;
    logic [2:0]       low_idx;
    logic             pair_valid;
    logic             pair_equal;
    logic             capture;
    logic [3:0]       dec_code;
    logic             dec_err;
    logic [N_DIG-1:0] seen_next;

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0010000: r = {1'b0, 4'h9};
            7'b0001001: r = {1'b0, 4'hA};   // 'H' glyph
            7'b1111111: r = {1'b0, 4'hB};   // blank
            default:    r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        n_low   = '0;
        low_idx = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (!an_s[i]) begin
                n_low   = n_low + 4'd1;
                low_idx = 3'(i);
            end
        end
    end

    assign pair_valid = (n_low == 4'd1);
    assign pair_equal = (an_s == an_p) && (seg_s == seg_p);
    assign capture    = pair_valid && pair_equal && armed && (cnt == CNT_CAP);
    assign {dec_err, dec_code} = decode(seg_s);
    assign seen_next  = seen | (N_DIG'(1) << low_idx);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_m  <= '1;
            an_s  <= '1;
            an_p  <= '1;
            seg_m <= '1;
            seg_s <= '1;
            seg_p <= '1;
        end else begin
            an_m  <= bus.an_i;
            an_s  <= an_m;
            an_p  <= an_s;
            seg_m <= bus.seg_i;
            seg_s <= seg_m;
            seg_p <= seg_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else if (!pair_valid || !pair_equal) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            if (cnt != CNT_SAT) begin
                cnt <= cnt + 8'd1;
            end
            if (capture) begin
                armed <= 1'b0;
            end
        end
    end

    // NOTE: the digit registers are a small readout bank, not a RAM, and
    // must show "blank" after reset, so they take the async reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= {N_DIG{4'hB}};
            err_q    <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
            frame_q  <= 1'b0;
            seen     <= '0;
        end else begin
            upd_q   <= 1'b0;
            frame_q <= 1'b0;
            if (capture) begin
                digits_q[4*int'(low_idx) +: 4] <= dec_code;
                err_q[low_idx]                 <= dec_err;
                upd_q                          <= 1'b1;
                idx_q                          <= low_idx;
                if (&seen_next) begin
                    frame_q <= 1'b1;
                    seen    <= '0;
                end else begin
                    seen    <= seen_next;
                end
            end
        end
    end

    assign bus.digits_o  = digits_q;
    assign bus.err_o     = err_q;
    assign bus.upd_o     = upd_q;
    assign bus.upd_idx_o = idx_q;
    assign bus.frame_o   = frame_q;
endmodule

// File: tb/tb_seg7_capture.sv
// ---------------------------------------------------------------------------
// tb_seg7_capture
// Directed stimulus on the display bus. A sample-history model predicts every
// output each cycle; hand-computed literals pin the model at key points.
// ---------------------------------------------------------------------------
module tb_seg7_capture;
    localparam int N_DIG      = 8;
    localparam int STABLE_CYC = 16;

    logic clk;
    logic rst;

    seg7_capture_if #(.N_DIG(N_DIG)) bus ();

    seg7_capture #(
        .N_DIG      (N_DIG),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Glyphs by code: index 10 is 'H', index 11 is blank.
    logic [6:0] glyph [0:11] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                 7'b0110000, 7'b0011001, 7'b0010010,
                                 7'b0000010, 7'b1111000, 7'b0000000,
                                 7'b0010000, 7'b0001001, 7'b1111111};

    // ---------------- behavioural model ----------------
    // A capture happens two edges after the input pair has been sampled
    // STABLE_CYC times in a row, provided exactly one anode is low.
    typedef struct {
        int         due;
        int         k;
        logic [3:0] code;
        logic       err;
    } cap_t;

    cap_t       pend[$];
    int         cyc;
    int         run;
    logic [7:0] prev_an;
    logic [6:0] prev_seg;
    logic [31:0] m_digits;
    logic [7:0]  m_err;
    logic        m_upd;
    logic [2:0]  m_idx;
    logic        m_frame;
    logic [7:0]  m_seen;

    always @(posedge clk or posedge rst) begin
        cap_t c;
        int   k;
        int   found;
        if (rst) begin
            pend.delete();
            cyc      = 0;
            run      = 0;
            prev_an  = '1;
            prev_seg = '1;
            m_digits = {8{4'hB}};
            m_err    = '0;
            m_upd    = 1'b0;
            m_idx    = '0;
            m_frame  = 1'b0;
            m_seen   = '0;
        end else begin
            cyc++;
            m_upd   = 1'b0;
            m_frame = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                c = pend.pop_front();
                m_digits[4*c.k +: 4] = c.code;
                m_err[c.k] = c.err;
                m_upd      = 1'b1;
                m_idx      = 3'(c.k);
                m_seen[c.k] = 1'b1;
                if (m_seen == 8'hFF) begin
                    m_frame = 1'b1;
                    m_seen  = '0;
                end
            end
            if (bus.an_i == prev_an && bus.seg_i == prev_seg) run++;
            else run = 1;
            prev_an  = bus.an_i;
            prev_seg = bus.seg_i;
            if (run == STABLE_CYC && $countones(~bus.an_i) == 1) begin
                k = 0;
                for (int i = 0; i < N_DIG; i++) if (!bus.an_i[i]) k = i;
                found = -1;
                for (int j = 0; j < 12; j++) if (glyph[j] == bus.seg_i) found = j;
                c.due  = cyc + 2;
                c.k    = k;
                c.code = (found >= 0) ? 4'(found) : 4'hF;
                c.err  = (found < 0);
                pend.push_back(c);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("digits", bus.digits_o, m_digits);
            check("err", 32'(bus.err_o), 32'(m_err));
            check("upd", 32'(bus.upd_o), 32'(m_upd));
            check("frame", 32'(bus.frame_o), 32'(m_frame));
            if (m_upd) check("upd_idx", 32'(bus.upd_idx_o), 32'(m_idx));
        end
    end

    // Pulse counters, sampled just after each rising edge.
    int upd_cnt   = 0;
    int frame_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst && bus.upd_o)   upd_cnt++;
        if (!rst && bus.frame_o) frame_cnt++;
    end

    task automatic set_pair(input logic [7:0] an, input logic [6:0] seg);
        @(negedge clk);
        bus.an_i  = an;
        bus.seg_i = seg;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base_u;
    int base_f;

    initial begin
        rst       = 1'b1;
        bus.an_i  = 8'hFF;
        bus.seg_i = 7'h7F;
        hold(3);
        check("rst_digits", bus.digits_o, 32'hBBBBBBBB);
        check("rst_err", 32'(bus.err_o), 32'h0);
        check("rst_upd", 32'(bus.upd_o), 32'h0);
        check("rst_idx", 32'(bus.upd_idx_o), 32'h0);
        check("rst_frame", 32'(bus.frame_o), 32'h0);
        rst = 1'b0;
        hold(2);

        // Single held pair: digit 0 shows '2'; pulse on edge 18, once.
        base_u = upd_cnt;
        set_pair(~8'h01, 7'b0100100);
        repeat (17) @(posedge clk);
        #1 check("lat_before", 32'(bus.upd_o), 32'h0);
        @(posedge clk);
        #1 check("lat_edge18", 32'(bus.upd_o), 32'h1);
        check("lat_idx", 32'(bus.upd_idx_o), 32'h0);
        check("lat_code", 32'(bus.digits_o[3:0]), 32'h2);
        check("lat_err", 32'(bus.err_o[0]), 32'h0);
        hold(30);
        check("single_pulse", 32'(upd_cnt - base_u), 32'd1);

        // Full scan of digits 0..7 showing 0..7.
        base_u = upd_cnt;
        base_f = frame_cnt;
        for (int d = 0; d < 8; d++) begin
            set_pair(~(8'h01 << d), glyph[d]);
            hold(23);
        end
        set_pair(8'hFF, 7'h7F);
        hold(3);
        check("scan_upd_cnt", 32'(upd_cnt - base_u), 32'd8);
        check("scan_frame_cnt", 32'(frame_cnt - base_f), 32'd1);
        check("scan_digits", bus.digits_o, 32'h76543210);
        check("scan_err", 32'(bus.err_o), 32'h0);

        // Segments toggling every 10 cycles never settle long enough.
        base_u = upd_cnt;
        set_pair(~8'h08, glyph[1]);
        for (int t = 0; t < 8; t++) begin
            hold(9);
            set_pair(~8'h08, (t % 2 == 0) ? glyph[8] : glyph[1]);
        end
        hold(9);
        check("toggle_no_upd", 32'(upd_cnt - base_u), 32'd0);

        // Two anodes low, then none low: never captured.
        base_u = upd_cnt;
        set_pair(~8'h03, glyph[3]);
        hold(40);
        set_pair(8'hFF, glyph[3]);
        hold(40);
        check("invalid_no_upd", 32'(upd_cnt - base_u), 32'd0);

        // 'H' glyph decodes to A; unknown pattern decodes to F with err.
        set_pair(~8'h04, 7'b0001001);
        hold(24);
        check("h_code", 32'(bus.digits_o[11:8]), 32'hA);
        check("h_err", 32'(bus.err_o[2]), 32'h0);
        set_pair(~8'h20, 7'b1010101);
        hold(24);
        check("bad_code", 32'(bus.digits_o[23:20]), 32'hF);
        check("bad_err", 32'(bus.err_o), 32'h20);
        check("mix_digits", bus.digits_o, 32'h76F43A10);

        // Reset partway through an episode, pair held across reset.
        set_pair(~8'h10, 7'b0010000);
        repeat (13) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_digits", bus.digits_o, 32'hBBBBBBBB);
        check("midrst_err", 32'(bus.err_o), 32'h0);
        check("midrst_upd", 32'(bus.upd_o), 32'h0);
        hold(2);
        @(negedge clk);
        rst = 1'b0;
        repeat (17) @(posedge clk);
        #1 check("rel_before", 32'(bus.upd_o), 32'h0);
        @(posedge clk);
        #1 check("rel_edge18", 32'(bus.upd_o), 32'h1);
        check("rel_idx", 32'(bus.upd_idx_o), 32'h4);
        check("rel_digits", bus.digits_o, 32'hBBB9BBBB);

        set_pair(8'hFF, 7'h7F);
        hold(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
